// File: rtl/fc_neuron_mac_if.sv
// fc_neuron_mac_if: bundle between a controller and the fc_neuron_mac
// multiply-accumulate stage.
//   values          layer outputs; element i is values[i]
//   w_load_en       weight write strobe (index in w_load_address)
//   w_load_address  weight index
//   w_load_value    weight data, also the bias data
//   b_load_en       bias write strobe
//   start           begin a computation (level sampled)
//   busy            computation in progress
//   done            one-cycle pulse, result valid from this cycle
//   result          saturated neuron output
// master = controller side, slave = fc_neuron_mac side.
interface fc_neuron_mac_if #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 2
);
  logic [LAYER_SZ-1:0][SIZE-1:0] values;
  logic                          w_load_en;
  logic [SIZE-1:0]               w_load_address;
  logic [SIZE-1:0]               w_load_value;
  logic                          b_load_en;
  logic                          start;
  logic                          busy;
  logic                          done;
  logic [SIZE-1:0]               result;

  modport master (
    output values, w_load_en, w_load_address, w_load_value, b_load_en, start,
    input  busy, done, result
  );

  modport slave (
    input  values, w_load_en, w_load_address, w_load_value, b_load_en, start,
    output busy, done, result
  );
endinterface

// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac: sequential multiply-accumulate for one fully connected neuron.
// Snapshots the layer value vector on start, accumulates one product of
// value and locally stored weight per clock on top of the bias, then emits
// a saturated Q(SIZE-FRAC).FRAC result with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fc_neuron_mac_if slave modport (load port, start/busy/done/result)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; weight/bias writes accepted
// ST_ACC   | adding snap[idx] * weight[idx] into acc, one per clock
// ST_OUT   | saturating acc into result, done pulses on leaving
module fc_neuron_mac #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 2,
  parameter int FRAC     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fc_neuron_mac_if.slave       bus
);

  localparam int IDXW  = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
  localparam int PRODW = 2 * SIZE;
  // Headroom for LAYER_SZ products plus the shifted bias: no overflow possible.
  localparam int ACCW  = PRODW + $clog2(LAYER_SZ + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } state_t;

  state_t                        state_q, state_d;
  logic [LAYER_SZ-1:0][SIZE-1:0] snap_q, snap_d;
  logic [LAYER_SZ-1:0][SIZE-1:0] weight_q, weight_d;
  logic [SIZE-1:0]               bias_q, bias_d;
  logic signed [ACCW-1:0]        acc_q, acc_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [SIZE-1:0]               result_q, result_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [SIZE-1:0]               bias_eff;
  logic signed [ACCW-1:0]        bias_ext;
  logic signed [PRODW-1:0]       prod;
  logic signed [ACCW-1:0]        prod_ext;
  logic signed [ACCW-1:0]        acc_sh;
  logic [ACCW-SIZE:0]            acc_hi;
  logic [SIZE-1:0]               sat_val;

  always_comb begin
    // A bias write in the same cycle as start must seed the accumulator.
    bias_eff = (bus.b_load_en && !busy_q) ? bus.w_load_value : bias_q;
    bias_ext = {{(ACCW-SIZE){bias_eff[SIZE-1]}}, bias_eff};

    prod     = $signed(snap_q[idx_q]) * $signed(weight_q[idx_q]);
    prod_ext = {{(ACCW-PRODW){prod[PRODW-1]}}, prod};

    // In range only if every bit above the result's sign bit matches it.
    acc_sh = acc_q >>> FRAC;
    acc_hi = acc_sh[ACCW-1:SIZE-1];
    if ((acc_hi == '0) || (acc_hi == '1)) begin
      sat_val = acc_sh[SIZE-1:0];
    end else if (acc_sh[ACCW-1]) begin
      sat_val = {1'b1, {(SIZE-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(SIZE-1){1'b1}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (!busy_q) begin
      if (bus.w_load_en && (bus.w_load_address < SIZE'(LAYER_SZ))) begin
        for (int i = 0; i < LAYER_SZ; i++) begin
          if (bus.w_load_address == SIZE'(i)) begin
            weight_d[i] = bus.w_load_value;
          end
        end
      end
      if (bus.b_load_en) begin
        bias_d = bus.w_load_value;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          snap_d  = bus.values;
          acc_d   = bias_ext <<< FRAC;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + IDXW'(1);
        if (idx_q == IDXW'(LAYER_SZ - 1)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        result_d = sat_val;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      snap_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
